// File: rtl/idli_serial_dcd_m.sv
// idli_serial_dcd_m
// Multi-context serial instruction decoder. Each context assembles a 16-bit
// encoding from BEAT_W-bit beats. Completed ops are offered to execute over a
// valid/ready handshake, with round-robin arbitration between FULL contexts.
// Operand fields are sliced combinationally from the granted context.
module idli_serial_dcd_m #(
  parameter int  BEAT_W   = 4,
  parameter int  NUM_CTX  = 2,
  parameter int  DROP_NOP = 1,
  localparam int CTX_W    = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic               i_dcd_gck,
  input  logic               i_dcd_rst_n,
  input  logic [BEAT_W-1:0]  i_dcd_enc,
  input  logic [CTX_W-1:0]   i_dcd_enc_ctx,
  input  logic               i_dcd_enc_vld,
  output logic               o_dcd_enc_rdy,
  input  logic [NUM_CTX-1:0] i_dcd_flush,
  output logic               o_dcd_op_vld,
  input  logic               i_dcd_op_rdy,
  output logic [CTX_W-1:0]   o_dcd_op_ctx,
  output logic [15:0]        o_dcd_op_enc,
  output logic [1:0]         o_dcd_op_p,
  output logic [2:0]         o_dcd_op_a,
  output logic [2:0]         o_dcd_op_b,
  output logic [2:0]         o_dcd_op_c,
  output logic               o_dcd_op_c_imm
);

  localparam int BEATS = 16 / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
  localparam logic [CTX_W-1:0] LAST_CTX = CTX_W'(NUM_CTX - 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FILL  = 2'b01,
    ST_FULL  = 2'b10
  } ctx_st_e;

  // NOP: zero major opcode with enc[8] clear (enc[8]=1 is branch-on-zero).
  function automatic logic is_nop(input logic [15:0] enc);
    return (enc[15:12] == 4'b0000) && (enc[8] == 1'b0);
  endfunction

  // NOP and branch-on-zero always execute unconditionally (PT).
  function automatic logic [1:0] pred(input logic [15:0] enc);
    return (enc[15:12] == 4'b0000) ? 2'b00 : enc[10:9];
  endfunction

  ctx_st_e            st_r  [NUM_CTX];
  logic [CNT_W-1:0]   cnt_r [NUM_CTX];
  logic [15:0]        sr_r  [NUM_CTX];
  logic [15:0]        asm_s [NUM_CTX];
  logic [NUM_CTX-1:0] full_s;
  logic [CTX_W-1:0]   rr_r;
  logic [CTX_W-1:0]   lock_ctx_r;
  logic               lock_r;
  logic [CTX_W-1:0]   pick_s;
  logic               pick_vld_s;
  logic [CTX_W-1:0]   gnt_s;
  logic               vld_s;
  logic               hs_s;
  logic               accept_s;
  logic [15:0]        op_enc_s;

  // Shift-register image each context would take if the current beat lands in it
  always_comb begin
    for (int k = 0; k < NUM_CTX; k++) begin
      asm_s[k]  = (sr_r[k] << BEAT_W) | 16'(i_dcd_enc);
      full_s[k] = (st_r[k] == ST_FULL);
    end
  end

  // Round-robin pick: scan backwards from the far end so the FULL context nearest the pointer wins
  always_comb begin
    pick_vld_s = 1'b0;
    pick_s     = {CTX_W{1'b0}};
    for (int i = NUM_CTX - 1; i >= 0; i--) begin
      if (full_s[CTX_W'((int'(rr_r) + i) % NUM_CTX)]) begin
        pick_vld_s = 1'b1;
        pick_s     = CTX_W'((int'(rr_r) + i) % NUM_CTX);
      end else begin
        pick_vld_s = pick_vld_s;
      end
    end
  end

  // Grant selection (a locked grant overrides the pick), handshake and beat acceptance
  always_comb begin
    if (lock_r) begin
      gnt_s = lock_ctx_r;
      vld_s = full_s[lock_ctx_r];
    end else begin
      gnt_s = pick_s;
      vld_s = pick_vld_s;
    end
    hs_s          = vld_s && i_dcd_op_rdy;
    // A flushed context takes (and drops) a beat even while it is FULL.
    o_dcd_enc_rdy = (st_r[i_dcd_enc_ctx] != ST_FULL) || i_dcd_flush[i_dcd_enc_ctx];
    accept_s      = i_dcd_enc_vld && o_dcd_enc_rdy;
  end

  // Output fields sliced from the granted context; forced to zero when nothing is offered
  always_comb begin
    if (vld_s) begin
      op_enc_s     = sr_r[gnt_s];
      o_dcd_op_ctx = gnt_s;
    end else begin
      op_enc_s     = 16'h0000;
      o_dcd_op_ctx = {CTX_W{1'b0}};
    end
    o_dcd_op_vld   = vld_s;
    o_dcd_op_enc   = op_enc_s;
    o_dcd_op_p     = pred(op_enc_s);
    o_dcd_op_a     = op_enc_s[8:6];
    o_dcd_op_b     = op_enc_s[5:3];
    o_dcd_op_c     = op_enc_s[2:0];
    o_dcd_op_c_imm = &op_enc_s[2:0];
  end

  // Per-context assembly state: beat shifting, completion, NOP squash, release on handshake, flush
  always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
    if (!i_dcd_rst_n) begin
      for (int k = 0; k < NUM_CTX; k++) begin
        st_r[k]  <= ST_EMPTY;
        cnt_r[k] <= {CNT_W{1'b0}};
        sr_r[k]  <= 16'h0000;
      end
    end else begin
      for (int k = 0; k < NUM_CTX; k++) begin
        if (i_dcd_flush[k]) begin
          st_r[k]  <= ST_EMPTY;
          cnt_r[k] <= {CNT_W{1'b0}};
          sr_r[k]  <= 16'h0000;
        end else begin
          case (st_r[k])
            ST_EMPTY, ST_FILL: begin
              if (accept_s && (i_dcd_enc_ctx == CTX_W'(k))) begin
                sr_r[k] <= asm_s[k];
                if (cnt_r[k] == LAST_CNT) begin
                  cnt_r[k] <= {CNT_W{1'b0}};
                  st_r[k]  <= ((DROP_NOP != 0) && is_nop(asm_s[k])) ? ST_EMPTY : ST_FULL;
                end else begin
                  cnt_r[k] <= cnt_r[k] + CNT_W'(1);
                  st_r[k]  <= ST_FILL;
                end
              end else begin
                st_r[k] <= st_r[k];
              end
            end
            ST_FULL: begin
              if (hs_s && (gnt_s == CTX_W'(k))) begin
                st_r[k] <= ST_EMPTY;
              end else begin
                st_r[k] <= ST_FULL;
              end
            end
            default: begin
              st_r[k]  <= ST_EMPTY;
              cnt_r[k] <= {CNT_W{1'b0}};
            end
          endcase
        end
      end
    end
  end

  // Arbitration state: pointer advances past the granted ctx on handshake; grant locks while stalled
  always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
    if (!i_dcd_rst_n) begin
      rr_r       <= {CTX_W{1'b0}};
      lock_r     <= 1'b0;
      lock_ctx_r <= {CTX_W{1'b0}};
    end else begin
      if (hs_s) begin
        rr_r <= (gnt_s == LAST_CTX) ? {CTX_W{1'b0}} : gnt_s + CTX_W'(1);
      end else begin
        rr_r <= rr_r;
      end
      // Flushing the granted ctx withdraws its op, so the lock must not survive it.
      lock_r     <= vld_s && !i_dcd_op_rdy && !i_dcd_flush[gnt_s];
      lock_ctx_r <= gnt_s;
    end
  end

endmodule

// File: tb/tb_idli_serial_dcd_m.sv
// tb_idli_serial_dcd_m
// Directed scenarios plus a randomized run for the 4-bit/2-context decoder,
// checked against a transaction-level reference model. A second instance
// with 16-bit beats covers the single-beat configuration.
module tb_idli_serial_dcd_m;

  localparam int BW    = 4;
  localparam int NC    = 2;
  localparam int CW    = 1;
  localparam int BEATS = 16 / BW;

  logic gck = 1'b0;
  logic rst_n;
  always #5 gck = ~gck;

  logic [BW-1:0] enc;
  logic [CW-1:0] enc_ctx;
  logic          enc_vld, enc_rdy;
  logic [NC-1:0] flush;
  logic          op_vld, op_rdy;
  logic [CW-1:0] op_ctx;
  logic [15:0]   op_enc;
  logic [1:0]    op_p;
  logic [2:0]    op_a, op_b, op_c;
  logic          op_c_imm;

  logic [15:0]   enc2;
  logic [CW-1:0] ctx2;
  logic          vld2, rdy2;
  logic [NC-1:0] flush2;
  logic          op_vld2, op_rdy2;
  logic [CW-1:0] op_ctx2;
  logic [15:0]   op_enc2;
  logic [1:0]    op_p2;
  logic [2:0]    op_a2, op_b2, op_c2;
  logic          op_c_imm2;

  idli_serial_dcd_m #(.BEAT_W(4), .NUM_CTX(2), .DROP_NOP(1)) dut (
    .i_dcd_gck(gck), .i_dcd_rst_n(rst_n),
    .i_dcd_enc(enc), .i_dcd_enc_ctx(enc_ctx), .i_dcd_enc_vld(enc_vld), .o_dcd_enc_rdy(enc_rdy),
    .i_dcd_flush(flush), .o_dcd_op_vld(op_vld), .i_dcd_op_rdy(op_rdy), .o_dcd_op_ctx(op_ctx),
    .o_dcd_op_enc(op_enc), .o_dcd_op_p(op_p), .o_dcd_op_a(op_a), .o_dcd_op_b(op_b),
    .o_dcd_op_c(op_c), .o_dcd_op_c_imm(op_c_imm)
  );

  idli_serial_dcd_m #(.BEAT_W(16), .NUM_CTX(2), .DROP_NOP(1)) dut16 (
    .i_dcd_gck(gck), .i_dcd_rst_n(rst_n),
    .i_dcd_enc(enc2), .i_dcd_enc_ctx(ctx2), .i_dcd_enc_vld(vld2), .o_dcd_enc_rdy(rdy2),
    .i_dcd_flush(flush2), .o_dcd_op_vld(op_vld2), .i_dcd_op_rdy(op_rdy2), .o_dcd_op_ctx(op_ctx2),
    .o_dcd_op_enc(op_enc2), .o_dcd_op_p(op_p2), .o_dcd_op_a(op_a2), .o_dcd_op_b(op_b2),
    .o_dcd_op_c(op_c2), .o_dcd_op_c_imm(op_c_imm2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: beats collected per context, completed op waiting per context.
  int          nb       [NC];
  logic [15:0] pv       [NC];
  bit          pend     [NC];
  logic [15:0] pend_enc [NC];
  int          rr;
  bit          lock;
  int          lock_ctx;
  bit          e_vld, e_rdy;
  int          e_gnt;

  function automatic int m_p(int e);
    return (((e / 4096) % 16) == 0) ? 0 : (e / 512) % 4;
  endfunction
  function automatic int m_a(int e);
    return (e / 64) % 8;
  endfunction
  function automatic int m_b(int e);
    return (e / 8) % 8;
  endfunction
  function automatic int m_c(int e);
    return e % 8;
  endfunction
  function automatic bit m_nop(int e);
    return (((e / 4096) % 16) == 0) && (((e / 256) % 2) == 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      nb[k] = 0; pv[k] = 16'h0; pend[k] = 1'b0; pend_enc[k] = 16'h0;
    end
    rr = 0; lock = 1'b0; lock_ctx = 0;
  endtask

  task automatic model_eval();
    bit found;
    found = 1'b0; e_vld = 1'b0; e_gnt = 0;
    if (lock) begin
      e_vld = 1'b1; e_gnt = lock_ctx;
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (!found && pend[(rr + i) % NC]) begin
          found = 1'b1; e_vld = 1'b1; e_gnt = (rr + i) % NC;
        end
      end
    end
    e_rdy = !pend[int'(enc_ctx)] || flush[int'(enc_ctx)];
  endtask

  task automatic model_commit();
    int c;
    bit acc;
    c   = int'(enc_ctx);
    acc = enc_vld && e_rdy && !flush[c];
    if (e_vld && op_rdy) begin
      pend[e_gnt] = 1'b0;
      rr = (e_gnt + 1) % NC;
    end
    lock     = e_vld && !op_rdy && !flush[e_gnt];
    lock_ctx = e_gnt;
    for (int k = 0; k < NC; k++) begin
      if (flush[k]) begin
        nb[k] = 0; pv[k] = 16'h0; pend[k] = 1'b0;
      end
    end
    if (acc) begin
      pv[c] = 16'((int'(pv[c]) * (1 << BW) + int'(enc)) % 65536);
      nb[c] = nb[c] + 1;
      if (nb[c] == BEATS) begin
        nb[c] = 0;
        if (!m_nop(int'(pv[c]))) begin
          pend[c] = 1'b1; pend_enc[c] = pv[c];
        end
      end
    end
  endtask

  task automatic half();
    @(negedge gck);
    model_eval();
  endtask

  task automatic edge_();
    @(posedge gck);
    if (rst_n) model_commit(); else model_reset();
    #1;
  endtask

  task automatic idle();
    enc_vld = 1'b0; enc = 4'h0; enc_ctx = 1'b0; flush = 2'b00; op_rdy = 1'b0;
  endtask

  task automatic beat(int ctx, int val);
    enc_vld = 1'b1; enc_ctx = CW'(ctx); enc = BW'(val);
    half();
    edge_();
    enc_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    enc2 = 16'h0; ctx2 = 1'b0; vld2 = 1'b0; flush2 = 2'b00; op_rdy2 = 1'b1;
    model_reset();
    repeat (2) edge_();
    half();
    checks++;
    if (op_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %0b want 0", op_vld); end
    checks++;
    if (op_enc !== 16'h0 || op_ctx !== 1'b0 || op_p !== 2'b0 || op_a !== 3'b0 || op_b !== 3'b0 ||
        op_c !== 3'b0 || op_c_imm !== 1'b0) begin
      errors++; $display("FAIL reset_fields got enc=%h ctx=%0d p=%0d a=%0d b=%0d c=%0d ci=%0b want all 0",
                         op_enc, op_ctx, op_p, op_a, op_b, op_c, op_c_imm);
    end
    checks++;
    if (enc_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %0b want 1", enc_rdy); end
    checks++;
    if (op_vld2 !== 1'b0) begin errors++; $display("FAIL reset_vld16 got %0b want 0", op_vld2); end
    edge_();
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [3:0] bts [4];
    bts = '{4'hC, 4'h1, 4'h2, 4'hB};
    for (int i = 0; i < 4; i++) begin
      enc_vld = 1'b1; enc_ctx = 1'b0; enc = bts[i];
      half();
      checks++;
      if (enc_rdy !== 1'b1 || op_vld !== 1'b0) begin
        errors++; $display("FAIL basic_beat%0d got rdy=%0b vld=%0b want rdy=1 vld=0", i, enc_rdy, op_vld);
      end
      edge_();
    end
    idle(); op_rdy = 1'b1;
    half();
    checks++;
    if (op_vld !== 1'b1 || op_enc !== 16'hC12B || op_ctx !== 1'b0) begin
      errors++; $display("FAIL basic_op got vld=%0b enc=%h ctx=%0d want 1 c12b 0", op_vld, op_enc, op_ctx);
    end
    checks++;
    if (op_p !== 2'd0 || op_a !== 3'b100 || op_b !== 3'b101 || op_c !== 3'd3 || op_c_imm !== 1'b0) begin
      errors++; $display("FAIL basic_fields got p=%0d a=%b b=%b c=%0d ci=%0b want 0 100 101 3 0",
                         op_p, op_a, op_b, op_c, op_c_imm);
    end
    edge_();
    op_rdy = 1'b0;
    half();
    checks++;
    if (op_vld !== 1'b0) begin errors++; $display("FAIL basic_release got vld=%0b want 0", op_vld); end
    edge_();
  endtask

  task automatic test_nop();
    logic [3:0] bts [8];
    bts = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h5, 4'h6, 4'h7};
    for (int i = 0; i < 8; i++) begin
      enc_vld = 1'b1; enc_ctx = 1'b1; enc = bts[i];
      half();
      checks++;
      if (enc_rdy !== 1'b1 || op_vld !== 1'b0) begin
        errors++; $display("FAIL nop_beat%0d got rdy=%0b vld=%0b want rdy=1 vld=0", i, enc_rdy, op_vld);
      end
      edge_();
    end
    idle(); op_rdy = 1'b1;
    half();
    checks++;
    if (op_vld !== 1'b1 || op_enc !== 16'h4567 || op_ctx !== 1'b1) begin
      errors++; $display("FAIL nop_next got vld=%0b enc=%h ctx=%0d want 1 4567 1", op_vld, op_enc, op_ctx);
    end
    edge_();
    op_rdy = 1'b0;
  endtask

  task automatic test_flush();
    beat(0, 1);
    beat(0, 2);
    enc_vld = 1'b1; enc_ctx = 1'b0; enc = 4'h9; flush = 2'b01;
    half();
    checks++;
    if (enc_rdy !== 1'b1) begin errors++; $display("FAIL flush_rdy got %0b want 1", enc_rdy); end
    edge_();
    flush = 2'b00;
    beat(0, 4); beat(0, 5); beat(0, 6); beat(0, 7);
    op_rdy = 1'b1;
    half();
    checks++;
    if (op_vld !== 1'b1 || op_enc !== 16'h4567 || op_ctx !== 1'b0) begin
      errors++; $display("FAIL flush_op got vld=%0b enc=%h ctx=%0d want 1 4567 0", op_vld, op_enc, op_ctx);
    end
    edge_();
    op_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      half();
      checks++;
      if (op_vld !== 1'b0) begin errors++; $display("FAIL flush_single%0d got vld=%0b want 0", i, op_vld); end
      edge_();
    end
  endtask

  task automatic test_hold();
    logic [3:0] b0 [4];
    b0 = '{4'h8, 4'h9, 4'hA, 4'hB};
    beat(1, 10); beat(1, 11); beat(1, 12); beat(1, 13);
    for (int i = 0; i < 4; i++) begin
      enc_vld = 1'b1; enc_ctx = 1'b0; enc = b0[i];
      half();
      checks++;
      if (op_vld !== 1'b1 || op_ctx !== 1'b1 || op_enc !== 16'hABCD) begin
        errors++; $display("FAIL hold_fill%0d got vld=%0b ctx=%0d enc=%h want 1 1 abcd", i, op_vld, op_ctx, op_enc);
      end
      edge_();
    end
    for (int i = 0; i < 5; i++) begin
      enc_vld = 1'b1; enc_ctx = 1'b1; enc = 4'hF;
      half();
      checks++;
      if (enc_rdy !== 1'b0 || op_ctx !== 1'b1 || op_enc !== 16'hABCD || op_p !== 2'd1 || op_a !== 3'd7 ||
          op_b !== 3'd1 || op_c !== 3'd5) begin
        errors++; $display("FAIL hold_stall%0d got rdy=%0b ctx=%0d enc=%h p=%0d a=%0d b=%0d c=%0d want 0 1 abcd 1 7 1 5",
                           i, enc_rdy, op_ctx, op_enc, op_p, op_a, op_b, op_c);
      end
      edge_();
    end
    idle(); op_rdy = 1'b1;
    half();
    checks++;
    if (op_vld !== 1'b1 || op_ctx !== 1'b1 || op_enc !== 16'hABCD) begin
      errors++; $display("FAIL hold_hs1 got vld=%0b ctx=%0d enc=%h want 1 1 abcd", op_vld, op_ctx, op_enc);
    end
    edge_();
    half();
    checks++;
    if (op_vld !== 1'b1 || op_ctx !== 1'b0 || op_enc !== 16'h89AB) begin
      errors++; $display("FAIL hold_hs0 got vld=%0b ctx=%0d enc=%h want 1 0 89ab", op_vld, op_ctx, op_enc);
    end
    edge_();
    op_rdy = 1'b0;
  endtask

  task automatic test_async_reset();
    beat(0, 1); beat(0, 2);
    beat(1, 3); beat(1, 4); beat(1, 5); beat(1, 6);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (op_vld !== 1'b0) begin errors++; $display("FAIL areset_vld got %0b want 0", op_vld); end
    model_reset();
    edge_();
    rst_n = 1'b1;
    beat(0, 7); beat(0, 8); beat(0, 9); beat(0, 10);
    op_rdy = 1'b1;
    half();
    checks++;
    if (op_vld !== 1'b1 || op_ctx !== 1'b0 || op_enc !== 16'h789A) begin
      errors++; $display("FAIL areset_op got vld=%0b ctx=%0d enc=%h want 1 0 789a", op_vld, op_ctx, op_enc);
    end
    edge_();
    half();
    checks++;
    if (op_vld !== 1'b0) begin errors++; $display("FAIL areset_empty got vld=%0b want 0", op_vld); end
    edge_();
    op_rdy = 1'b0;
  endtask

  task automatic test_b16();
    op_rdy2 = 1'b1;
    vld2 = 1'b1; ctx2 = 1'b0; enc2 = 16'hC12B;
    half();
    checks++;
    if (rdy2 !== 1'b1 || op_vld2 !== 1'b0) begin
      errors++; $display("FAIL b16_first got rdy=%0b vld=%0b want 1 0", rdy2, op_vld2);
    end
    edge_();
    ctx2 = 1'b1; enc2 = 16'hD007;
    half();
    checks++;
    if (rdy2 !== 1'b1 || op_vld2 !== 1'b1 || op_ctx2 !== 1'b0 || op_enc2 !== 16'hC12B || op_c_imm2 !== 1'b0) begin
      errors++; $display("FAIL b16_op0 got rdy=%0b vld=%0b ctx=%0d enc=%h ci=%0b want 1 1 0 c12b 0",
                         rdy2, op_vld2, op_ctx2, op_enc2, op_c_imm2);
    end
    edge_();
    vld2 = 1'b0;
    half();
    checks++;
    if (op_vld2 !== 1'b1 || op_ctx2 !== 1'b1 || op_enc2 !== 16'hD007 || op_c_imm2 !== 1'b1 || op_c2 !== 3'd7 ||
        op_p2 !== 2'd0) begin
      errors++; $display("FAIL b16_op1 got vld=%0b ctx=%0d enc=%h ci=%0b c=%0d p=%0d want 1 1 d007 1 7 0",
                         op_vld2, op_ctx2, op_enc2, op_c_imm2, op_c2, op_p2);
    end
    edge_();
    half();
    checks++;
    if (op_vld2 !== 1'b0) begin errors++; $display("FAIL b16_done got vld=%0b want 0", op_vld2); end
    edge_();
  endtask

  task automatic test_random();
    int g;
    for (int n = 0; n < 3000; n++) begin
      enc_vld = ($urandom_range(0, 9) < 6);
      enc_ctx = CW'($urandom_range(0, NC - 1));
      enc     = ($urandom_range(0, 3) == 0) ? 4'h0 : BW'($urandom_range(0, 15));
      for (int k = 0; k < NC; k++) flush[k] = ($urandom_range(0, 39) == 0);
      op_rdy  = ($urandom_range(0, 9) < 6);
      half();
      checks++;
      if (op_vld !== e_vld || enc_rdy !== e_rdy) begin
        errors++; $display("FAIL rnd_hs cyc %0d got vld=%0b rdy=%0b want %0b %0b", n, op_vld, enc_rdy, e_vld, e_rdy);
      end
      if (e_vld) begin
        g = e_gnt;
        checks++;
        if (op_ctx !== CW'(g) || op_enc !== pend_enc[g]) begin
          errors++; $display("FAIL rnd_op cyc %0d got ctx=%0d enc=%h want %0d %h", n, op_ctx, op_enc, g, pend_enc[g]);
        end
        checks++;
        if (op_p !== 2'(m_p(int'(pend_enc[g]))) || op_a !== 3'(m_a(int'(pend_enc[g]))) ||
            op_b !== 3'(m_b(int'(pend_enc[g]))) || op_c !== 3'(m_c(int'(pend_enc[g]))) ||
            op_c_imm !== (m_c(int'(pend_enc[g])) == 7)) begin
          errors++; $display("FAIL rnd_fields cyc %0d enc=%h got p=%0d a=%0d b=%0d c=%0d ci=%0b", n, pend_enc[g],
                             op_p, op_a, op_b, op_c, op_c_imm);
        end
      end
      edge_();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nop();
    test_flush();
    test_hold();
    test_async_reset();
    test_b16();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
